// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants.
// Imported by the ID/EX stage and its forwarding muxes.
package pipe_pkg;

  typedef enum logic [4:0] {
    ADD = 5'd0,
    SUB,
    AND,
    OR,
    XOR,
    SLL,
    SRL,
    SLA,
    SRA,
    LUI,
    LLI
  } alu_op_t;

  localparam int REG_AW   = 5;
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux for one source register.
// EX/MEM has priority over MEM/WB; register zero never forwards.
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int N   = 32,
  parameter int RAW = REG_AW
) (
  input  logic [RAW-1:0] idx,
  input  logic [N-1:0]   reg_val,
  input  logic           exm_reg_write,
  input  logic [RAW-1:0] exm_rd,
  input  logic [N-1:0]   exm_result,
  input  logic           wb_reg_write,
  input  logic [RAW-1:0] wb_rd,
  input  logic [N-1:0]   wb_data,
  output logic [N-1:0]   fwd
);

  logic nz;

  assign nz = (idx != RAW'(REG_ZERO));

  always_comb begin
    fwd = reg_val;
    if (nz && exm_reg_write && exm_rd == idx)
      fwd = exm_result;
    else if (nz && wb_reg_write && wb_rd == idx)
      fwd = wb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding,
// load-use stall detection and branch-flush handling.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int N   = 32,
  parameter int RAW = REG_AW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic [RAW-1:0] id_rs,
  input  logic [RAW-1:0] id_rt,
  input  logic [RAW-1:0] id_rd,
  input  logic [N-1:0]   id_rs_data,
  input  logic [N-1:0]   id_rt_data,
  input  logic [15:0]    id_imm,
  input  logic           id_use_imm,
  input  logic [4:0]     id_op,
  input  logic           id_reg_write,
  input  logic           id_mem_read,
  input  logic           id_mem_write,
  input  logic           flush,
  input  logic           exm_reg_write,
  input  logic [RAW-1:0] exm_rd,
  input  logic [N-1:0]   exm_result,
  input  logic           wb_reg_write,
  input  logic [RAW-1:0] wb_rd,
  input  logic [N-1:0]   wb_data,
  output logic           stall_o,
  output logic           ex_valid,
  output logic [N-1:0]   ex_a,
  output logic [N-1:0]   ex_b,
  output logic [4:0]     ex_op,
  output logic [RAW-1:0] ex_rd,
  output logic [N-1:0]   ex_store_data,
  output logic           ex_reg_write,
  output logic           ex_mem_read,
  output logic           ex_mem_write
);

  logic           v_q;
  logic [RAW-1:0] rs_q;
  logic [RAW-1:0] rt_q;
  logic [RAW-1:0] rd_q;
  logic [N-1:0]   rsv_q;
  logic [N-1:0]   rtv_q;
  logic [15:0]    imm_q;
  logic           use_imm_q;
  alu_op_t        op_q;
  ctrl_t          ctrl_q;

  logic           rt_used;
  logic           wt_rs;
  logic           wt_rt;
  logic [N-1:0]   fwd_rs;
  logic [N-1:0]   fwd_rt;

  assign rt_used = !id_use_imm || id_mem_write;

  assign stall_o = id_valid && ex_valid && ex_mem_read
                && (ex_rd != RAW'(REG_ZERO))
                && !flush && !rst
                && ((ex_rd == id_rs)
                    || (rt_used && ex_rd == id_rt));

  // Register file write in the same cycle is not yet visible on read data.
  assign wt_rs = wb_reg_write
              && (wb_rd != RAW'(REG_ZERO))
              && (wb_rd == id_rs);
  assign wt_rt = wb_reg_write
              && (wb_rd != RAW'(REG_ZERO))
              && (wb_rd == id_rt);

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q       <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rsv_q     <= '0;
      rtv_q     <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      op_q      <= ADD;
      ctrl_q    <= '0;
    end else if (flush || stall_o) begin
      v_q    <= 1'b0;
      ctrl_q <= '0;
    end else begin
      v_q       <= id_valid;
      rs_q      <= id_rs;
      rt_q      <= id_rt;
      rd_q      <= id_rd;
      rsv_q     <= wt_rs ? wb_data : id_rs_data;
      rtv_q     <= wt_rt ? wb_data : id_rt_data;
      imm_q     <= id_imm;
      use_imm_q <= id_use_imm;
      op_q      <= alu_op_t'(id_op);
      ctrl_q    <= '{reg_write: id_reg_write,
                     mem_read:  id_mem_read,
                     mem_write: id_mem_write};
    end
  end

  fwd_mux #(.N(N), .RAW(RAW)) u_fwd_rs (
    .idx           (rs_q),
    .reg_val       (rsv_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .fwd           (fwd_rs)
  );

  fwd_mux #(.N(N), .RAW(RAW)) u_fwd_rt (
    .idx           (rt_q),
    .reg_val       (rtv_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .fwd           (fwd_rt)
  );

  assign ex_valid      = v_q;
  assign ex_a          = fwd_rs;
  assign ex_b          = use_imm_q
                       ? {{(N-16){imm_q[15]}}, imm_q}
                       : fwd_rt;
  assign ex_op         = op_q;
  assign ex_rd         = rd_q;
  assign ex_store_data = fwd_rt;
  assign ex_reg_write  = v_q && ctrl_q.reg_write;
  assign ex_mem_read   = v_q && ctrl_q.mem_read;
  assign ex_mem_write  = v_q && ctrl_q.mem_write;

endmodule
